// File: rtl/lc3b_dcache_ctrl_if.sv
// lc3b_dcache_ctrl_if: CPU-side and physical-memory-side buses of the LC-3b data cache.
interface lc3b_dcache_ctrl_if;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_wmask;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    modport master (
        output mem_address, mem_read, mem_write, mem_wmask, mem_wdata, pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );
    modport slave (
        input  mem_address, mem_read, mem_write, mem_wmask, mem_wdata, pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface

// File: rtl/lc3b_dcache_ctrl.sv
// lc3b_dcache_ctrl: direct-mapped write-back write-allocate data cache, 8 lines of 128 bits.
module lc3b_dcache_ctrl (
    input logic clk,
    input logic rst_n,
    lc3b_dcache_ctrl_if.slave bus
);
    typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} state_t;
    state_t       state;
    logic [127:0] line [8];
    logic [8:0]   tag [8];
    logic [7:0]   valid, dirty;
    logic [2:0]   idx;
    logic [6:0]   lo, hi;
    logic         req, hit, wr_hit;
    always_comb begin
        idx = bus.mem_address[6:4];
        lo = {bus.mem_address[3:1], 4'b0000};
        hi = {bus.mem_address[3:1], 4'b1000};
        req = bus.mem_read | bus.mem_write;
        hit = valid[idx] && tag[idx] == bus.mem_address[15:7];
        wr_hit = state == CHECK && bus.mem_write && hit;
        bus.mem_resp = state == CHECK && req && hit;
        bus.mem_rdata = line[idx][lo +: 16];
        bus.pmem_wdata = line[idx];
        bus.pmem_address = state == WRITEBACK ? {tag[idx], idx, 4'b0} : {bus.mem_address[15:4], 4'b0};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CHECK;
            valid <= '0;
            dirty <= '0;
            bus.pmem_read <= 1'b0;
            bus.pmem_write <= 1'b0;
        end else begin
            case (state)
                CHECK:
                    if (wr_hit) dirty[idx] <= 1'b1;
                    else if (req && !hit) begin
                        state <= dirty[idx] ? WRITEBACK : ALLOCATE;
                        bus.pmem_write <= dirty[idx];
                        bus.pmem_read <= !dirty[idx];
                    end
                WRITEBACK:
                    if (bus.pmem_resp) begin
                        dirty[idx] <= 1'b0;
                        state <= ALLOCATE;
                        bus.pmem_write <= 1'b0;
                        bus.pmem_read <= 1'b1;
                    end
                ALLOCATE:
                    if (bus.pmem_resp) begin
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b0;
                        state <= CHECK;
                        bus.pmem_read <= 1'b0;
                    end
                default: state <= CHECK;
            endcase
        end
    end
    // data and tag arrays carry no reset; valid bits gate their use
    always_ff @(posedge clk) begin
        if (state == ALLOCATE && bus.pmem_resp) begin
            line[idx] <= bus.pmem_rdata;
            tag[idx] <= bus.mem_address[15:7];
        end
        if (wr_hit && bus.mem_wmask[0]) line[idx][lo +: 8] <= bus.mem_wdata[7:0];
        if (wr_hit && bus.mem_wmask[1]) line[idx][hi +: 8] <= bus.mem_wdata[15:8];
    end
endmodule

// File: tb/tb_lc3b_dcache_ctrl.sv
// tb_lc3b_dcache_ctrl: directed and random loads/stores against a flat-memory reference and a pmem model.
module tb_lc3b_dcache_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lc3b_dcache_ctrl_if bus();
    lc3b_dcache_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_assert = 0;
    int n_fail = 0;
    logic [127:0] pmem [4096];
    logic [15:0]  ref_mem [32768];
    logic [8:0]   mtag [8];
    logic [7:0]   mvalid, mdirty;
    int           wb_n, fill_n, wb_cyc, fill_cyc, rem;
    logic [15:0]  wb_addr, fill_addr, last_rdata;
    logic [127:0] wb_data;
    bit           hold, stray, busy;

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    function automatic logic [127:0] ref_line(input logic [11:0] l);
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[16*i +: 16] = ref_mem[{l, i[2:0]}];
        return v;
    endfunction

    // cached dirty data is lost on reset, so the visible memory becomes pmem again
    task automatic resync();
        for (int l = 0; l < 4096; l++)
            for (int i = 0; i < 8; i++) ref_mem[{l[11:0], i[2:0]}] = pmem[l][16*i +: 16];
        mvalid = '0;
        mdirty = '0;
    endtask

    initial begin
        bus.pmem_resp = 1'b0;
        bus.pmem_rdata = '0;
        busy = 0;
        rem = 0;
        forever begin
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (!rst_n) busy = 0;
            else if (stray) begin
                bus.pmem_resp = 1'b1;
                stray = 0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                chk("pmem_excl", bus.pmem_read & bus.pmem_write, 0);
                chk("resp_during_xfer", bus.mem_resp, 0);
                if (!busy) begin
                    busy = 1;
                    rem = $urandom_range(0, 2);
                end
                if (bus.pmem_write) wb_cyc++;
                else fill_cyc++;
                if (!hold && rem == 0) begin
                    busy = 0;
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_write) begin
                        pmem[bus.pmem_address[15:4]] = bus.pmem_wdata;
                        wb_n++;
                        wb_addr = bus.pmem_address;
                        wb_data = bus.pmem_wdata;
                    end else begin
                        bus.pmem_rdata = pmem[bus.pmem_address[15:4]];
                        fill_n++;
                        fill_addr = bus.pmem_address;
                    end
                end else if (rem > 0) rem--;
            end
        end
    end

    task automatic do_req(input bit rd, input bit wr, input logic [15:0] a, input logic [1:0] m, input logic [15:0] d);
        logic [2:0]   s;
        logic [8:0]   t;
        bit           hit, dwb;
        logic [15:0]  vaddr;
        logic [127:0] vdata;
        int           cyc;
        s = a[6:4];
        t = a[15:7];
        hit = mvalid[s] && mtag[s] == t;
        dwb = !hit && mvalid[s] && mdirty[s];
        vaddr = {mtag[s], s, 4'b0};
        vdata = ref_line({mtag[s], s});
        cyc = 0;
        wb_n = 0; fill_n = 0; wb_cyc = 0; fill_cyc = 0;
        bus.mem_address = a;
        bus.mem_read = rd;
        bus.mem_write = wr;
        bus.mem_wmask = m;
        bus.mem_wdata = d;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.mem_resp && cyc < 60);
        chk("resp_timeout", bus.mem_resp, 1);
        last_rdata = bus.mem_rdata;
        if (!wr) chk("rdata", bus.mem_rdata, ref_mem[a[15:1]]);
        chk("latency", cyc, hit ? 1 : wb_cyc + fill_cyc + 2);
        chk("wb_count", wb_n, dwb);
        if (dwb) begin
            chk("wb_addr", wb_addr, vaddr);
            chk("wb_data", wb_data, vdata);
        end
        chk("fill_count", fill_n, !hit);
        if (!hit) chk("fill_addr", fill_addr, {a[15:4], 4'b0});
        if (wr && m[0]) ref_mem[a[15:1]][7:0] = d[7:0];
        if (wr && m[1]) ref_mem[a[15:1]][15:8] = d[15:8];
        mtag[s] = t;
        mvalid[s] = 1'b1;
        mdirty[s] = (hit & mdirty[s]) | wr;
        @(posedge clk);
        #1;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] orig, a;
        int r;
        bus.mem_address = '0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_wmask = '0;
        bus.mem_wdata = '0;
        hold = 0;
        stray = 0;
        for (int l = 0; l < 4096; l++) pmem[l] = {$urandom(), $urandom(), $urandom(), $urandom()};
        resync();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_resp", bus.mem_resp, 0);
        chk("rst_pmem_read", bus.pmem_read, 0);
        chk("rst_pmem_write", bus.pmem_write, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_req(1, 0, 16'h1234, 2'b00, 16'h0);
        chk("t1_fill_addr", fill_addr, 16'h1230);
        chk("t1_word2", last_rdata, pmem[12'h123][47:32]);
        do_req(1, 0, 16'h1234, 2'b00, 16'h0);
        chk("t2_no_pmem", wb_n + fill_n, 0);

        orig = ref_mem[15'h091B];
        do_req(0, 1, 16'h1236, 2'b10, 16'hBEEF);
        do_req(1, 0, 16'h1236, 2'b00, 16'h0);
        chk("t3_merge", last_rdata, {8'hBE, orig[7:0]});

        do_req(1, 0, 16'h12B4, 2'b00, 16'h0);
        chk("t4_wb_addr", wb_addr, 16'h1230);
        chk("t4_fill_addr", fill_addr, 16'h12B0);

        bus.mem_address = 16'h1234;
        bus.mem_read = 1'b1;
        hold = 1;
        for (int i = 0; i < 10 && !bus.pmem_read; i++) @(negedge clk);
        chk("t5_in_allocate", bus.pmem_read, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_pmem_read", bus.pmem_read, 0);
        chk("t5_rst_pmem_write", bus.pmem_write, 0);
        chk("t5_rst_mem_resp", bus.mem_resp, 0);
        bus.mem_read = 1'b0;
        hold = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1;
        resync();
        repeat (3) @(negedge clk);
        chk("t5_stray_read", bus.pmem_read, 0);
        chk("t5_stray_write", bus.pmem_write, 0);
        @(posedge clk);
        #1;
        do_req(1, 0, 16'h12B4, 2'b00, 16'h0);
        chk("t5_remiss", fill_n, 1);

        do_req(1, 1, 16'h12B6, 2'b11, 16'hA5A5);
        do_req(1, 0, 16'h12B6, 2'b00, 16'h0);
        chk("t6_write_wins", last_rdata, 16'hA5A5);
        do_req(1, 0, 16'h1234, 2'b00, 16'h0);
        chk("t6_dirty_wb", wb_n, 1);

        do_req(1, 0, 16'h0000, 2'b00, 16'h0);
        do_req(1, 0, 16'h0080, 2'b00, 16'h0);
        do_req(1, 0, 16'h0000, 2'b00, 16'h0);
        chk("wrap_evict", fill_n, 1);
        do_req(1, 0, 16'h0001, 2'b00, 16'h0);
        chk("byte0_hit", fill_n, 0);

        repeat (300) begin
            a = {7'h24, 2'($urandom_range(0, 3)), 3'($urandom()), 3'($urandom()), 1'($urandom())};
            r = $urandom_range(0, 3);
            do_req(r != 1, r == 1 || r == 2, a, 2'($urandom()), 16'($urandom()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
